wb_master_mc: RTL

Multi-channel Wishbone master for the OpenMIPS core, the parametrised successor to the single-port bus bridge. It arbitrates round-robin between `NCH` requesters, such as MMU instruction and data sides, or a future DMA/cache refill port, and runs one classic Wishbone cycle at a time. Each requester gets per-channel stall, acknowledge and optional error signalling. It sits between the MMU-side request ports and the external Wishbone bus.

---
 rtl/wb_master_mc.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_master_mc.sv
// wb_master_mc -- multi-channel classic Wishbone master.
//
// This block arbitrates round-robin between NCH requesters. It runs one
// single-beat Wishbone cycle at a time. Each channel gets its own stall,
// acknowledge and (optionally) timeout-error signalling.
//
// Optional feature macro: WB_MASTER_MC_TIMEOUT_EN
//   When it is defined, a BUSY cycle that has seen no ack for TIMEOUT cycles
//   is aborted. The abort pulses rsp_err_o and zeroes rsp_data_o.
//   When it is undefined, rsp_err_o is tied low and BUSY waits indefinitely.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_ce_i        per-channel request
//   req_we_i        per-channel write enable
//   req_addr_i      per-channel address, channel i at [i*AW +: AW]
//   req_data_i      per-channel write data, channel i at [i*DW +: DW]
//   req_sel_i       per-channel byte selects, channel i at [i*SELW +: SELW]
//   req_hold_i      requester stage stalled; keeps a completed result "done"
//   req_flush_i     abort / clear channel i
//   rsp_data_o      read data of the last acknowledged transfer
//   rsp_ack_o       one-cycle completion pulse per channel
//   rsp_err_o       one-cycle timeout pulse per channel
//   stall_req_o     per-channel stall request
//   wb_*            Wishbone master side (cyc, stb, we, addr, data, sel / data_i, ack_i)
module wb_master_mc #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_ce_i,
  input  logic [NCH-1:0]       req_we_i,
  input  logic [NCH*AW-1:0]    req_addr_i,
  input  logic [NCH*DW-1:0]    req_data_i,
  input  logic [NCH*SELW-1:0]  req_sel_i,
  input  logic [NCH-1:0]       req_hold_i,
  input  logic [NCH-1:0]       req_flush_i,
  output logic [DW-1:0]        rsp_data_o,
  output logic [NCH-1:0]       rsp_ack_o,
  output logic [NCH-1:0]       rsp_err_o,
  output logic [NCH-1:0]       stall_req_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [AW-1:0]        wb_addr_o,
  output logic [DW-1:0]        wb_data_o,
  output logic [SELW-1:0]      wb_sel_o,
  input  logic [DW-1:0]        wb_data_i,
  input  logic                 wb_ack_i
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("wb_master_mc: NCH and TIMEOUT must both be >= 1");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q;
  logic [CW-1:0]   g_q;        // channel owning the current bus cycle
  logic [CW-1:0]   last_g_q;   // most recent grant, round-robin pointer
  logic [NCH-1:0]  done_q;     // result delivered, requester still holding it
  logic [NCH-1:0]  ack_q;
  logic            cyc_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SELW-1:0] sel_q;
  logic [DW-1:0]   rdata_q;

  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  done_keep;
  logic [NCH-1:0]  g_mask;
  logic [CW-1:0]   gnt_d;
  logic            gnt_vld;

  // A done bit survives only while its requester keeps holding and is not flushed.
  assign done_keep = done_q & req_hold_i & ~req_flush_i;
  assign elig      = req_ce_i & ~done_q & ~req_flush_i;

  always_comb begin
    g_mask        = '0;
    g_mask[g_q]   = 1'b1;
  end

  // Round-robin: search starts at the channel just after the last grant.
  always_comb begin
    int          idx;
    logic [CW-1:0] idx_c;
    idx     = 0;
    idx_c   = '0;
    gnt_d   = last_g_q;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(last_g_q) + k) % NCH;
      idx_c = CW'(idx);
      if (!gnt_vld && elig[idx_c]) begin
        gnt_vld = 1'b1;
        gnt_d   = idx_c;
      end
    end
  end

`ifdef WB_MASTER_MC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  cnt_q;
  logic [NCH-1:0] err_q;
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_g_q <= CW'(NCH - 1);
      done_q   <= '0;
      ack_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
`ifdef WB_MASTER_MC_TIMEOUT_EN
      err_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      ack_q  <= '0;
      done_q <= done_keep;
`ifdef WB_MASTER_MC_TIMEOUT_EN
      err_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          // Any wb_ack_i seen here is stray and deliberately ignored.
          if (gnt_vld) begin
            state_q  <= BUSY;
            g_q      <= gnt_d;
            last_g_q <= gnt_d;
            cyc_q    <= 1'b1;
            we_q     <= req_we_i[gnt_d];
            addr_q   <= req_addr_i[int'(gnt_d)*AW +: AW];
            wdata_q  <= req_data_i[int'(gnt_d)*DW +: DW];
            sel_q    <= req_sel_i[int'(gnt_d)*SELW +: SELW];
`ifdef WB_MASTER_MC_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        BUSY: begin
          // Flush beats a same-cycle ack: the requester no longer wants the result.
          if (req_flush_i[g_q]) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
          end else if (wb_ack_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= wb_data_i;
            ack_q   <= g_mask;
            done_q  <= done_keep | g_mask;
          end
`ifdef WB_MASTER_MC_TIMEOUT_EN
          else if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= g_mask;
            done_q  <= done_keep | g_mask;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_sel_o    = sel_q;
  assign rsp_data_o  = rdata_q;
  assign rsp_ack_o   = ack_q;
  assign stall_req_o = req_ce_i & ~done_q & ~ack_q & ~rsp_err_o & ~req_flush_i;

endmodule
